// File: rtl/dift_tag_init_engine.sv
`default_nettype none
`timescale 1ns/1ps
// dift_tag_init_engine: walks a word range on a TCDM master port and stamps a tag on each
// word, either preserving data (read-modify-write) or zero-filling it. Rev 1.0

module dift_tag_init_engine #(
  parameter int TAG_BITS_NUM = 4,
  parameter int RMW          = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [31:0]                addr_start_i,
  input  logic [31:0]                addr_end_i,
  input  logic [TAG_BITS_NUM-1:0]    tag_val_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic                       master_req_o,
  output logic [31:0]                master_add_o,
  output logic                       master_wen_o,
  output logic [3:0]                 master_be_o,
  output logic [31+TAG_BITS_NUM:0]   master_wdata_o,
  input  logic                       master_gnt_i,
  input  logic                       master_r_valid_i,
  input  logic                       master_r_opc_i,
  input  logic [31+TAG_BITS_NUM:0]   master_r_rdata_i
);

  localparam int   DW     = 32 + TAG_BITS_NUM;
  localparam logic RMW_EN = (RMW != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_RD_RSP = 3'd2,
    S_WR_REQ = 3'd3,
    S_WR_RSP = 3'd4,
    S_FIN    = 3'd5
  } state_e;

  state_e                  state_q, state_d, word_state;
  logic [31:0]             cur_addr_q, cur_addr_d;
  logic [31:0]             end_addr_q, end_addr_d;
  logic [31:0]             data_q, data_d;
  logic [TAG_BITS_NUM-1:0] tag_q, tag_d;
  logic                    abort_q, abort_d;
  logic                    err_q, err_d;
  logic                    req_q, req_d;
  logic                    wen_q, wen_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [31:0]             add_q, add_d;
  logic [3:0]              be_q, be_d;
  logic [DW-1:0]           wdata_q, wdata_d;

  logic [31:0]             start_al, end_al;
  logic [32:0]             next_addr;
  logic                    unused_bits;

  assign start_al    = {addr_start_i[31:2], 2'b00};
  assign end_al      = {addr_end_i[31:2], 2'b00};
  assign next_addr   = {1'b0, cur_addr_q} + 33'd4;
  assign word_state  = RMW_EN ? S_RD_REQ : S_WR_REQ;
  assign unused_bits = ^{addr_start_i[1:0], addr_end_i[1:0], master_r_rdata_i[DW-1:32]};

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    end_addr_d = end_addr_q;
    data_d     = data_q;
    tag_d      = tag_q;
    abort_d    = abort_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start_i) begin
          cur_addr_d = start_al;
          end_addr_d = end_al;
          tag_d      = tag_val_i;
          data_d     = 32'h0;
          err_d      = 1'b0;
          state_d    = (start_al >= end_al) ? S_FIN : word_state;
        end
      end
      S_RD_REQ, S_WR_REQ: begin
        // A grant wins over a simultaneous abort: the response must still be drained.
        if (master_gnt_i) begin
          abort_d = abort_i;
          state_d = (state_q == S_RD_REQ) ? S_RD_RSP : S_WR_RSP;
        end else if (abort_i) begin
          state_d = S_IDLE;
        end
      end
      S_RD_RSP: begin
        abort_d = abort_q | abort_i;
        if (master_r_valid_i) begin
          if (master_r_opc_i) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (abort_d) begin
            state_d = S_IDLE;
          end else begin
            data_d  = master_r_rdata_i[31:0];
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_RSP: begin
        abort_d = abort_q | abort_i;
        if (master_r_valid_i) begin
          cur_addr_d = next_addr[31:0];
          if (master_r_opc_i) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (abort_d) begin
            state_d = S_IDLE;
          end else if (next_addr[32] || (next_addr[31:0] >= end_addr_q)) begin
            state_d = S_FIN;
          end else begin
            state_d = word_state;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered, so they are derived from the next state.
    req_d   = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    wen_d   = (state_d != S_WR_REQ);
    be_d    = req_d ? 4'hF : 4'h0;
    add_d   = req_d ? cur_addr_d : 32'h0;
    wdata_d = (state_d == S_WR_REQ) ? {tag_d, (RMW_EN ? data_d : 32'h0)} : '0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cur_addr_q <= 32'h0;
      end_addr_q <= 32'h0;
      data_q     <= 32'h0;
      tag_q      <= '0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      wen_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      add_q      <= 32'h0;
      be_q       <= 4'h0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      end_addr_q <= end_addr_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
      req_q      <= req_d;
      wen_q      <= wen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      add_q      <= add_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign master_req_o   = req_q;
  assign master_add_o   = add_q;
  assign master_wen_o   = wen_q;
  assign master_be_o    = be_q;
  assign master_wdata_o = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dift_tag_init_engine.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for dift_tag_init_engine: one RMW=1 and one RMW=0 instance share a memory-backed
// bus responder; a range-level model predicts every bus transaction and the final outcome.

module tb_dift_tag_init_engine;

  logic        clk;
  logic        rst_ni;
  logic        start_v [2];
  logic        abort_i;
  logic [31:0] addr_start, addr_end;
  logic [3:0]  tag_val;
  logic        busy_v [2], done_v [2], err_v [2], req_v [2], wen_v [2];
  logic [31:0] add_v [2];
  logic [3:0]  be_v [2];
  logic [35:0] wdata_v [2];
  logic        gnt, r_valid, r_opc;
  logic [35:0] r_rdata;

  logic        sel;
  logic        busy, done, err, req, wen;
  logic [31:0] add;
  logic [3:0]  be;
  logic [35:0] wdata;

  always_comb begin
    busy  = busy_v[sel];
    done  = done_v[sel];
    err   = err_v[sel];
    req   = req_v[sel];
    wen   = wen_v[sel];
    add   = add_v[sel];
    be    = be_v[sel];
    wdata = wdata_v[sel];
  end

  dift_tag_init_engine #(.TAG_BITS_NUM(4), .RMW(1)) u_rmw (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_v[0]), .abort_i(abort_i),
    .addr_start_i(addr_start), .addr_end_i(addr_end), .tag_val_i(tag_val),
    .busy_o(busy_v[0]), .done_o(done_v[0]), .err_o(err_v[0]),
    .master_req_o(req_v[0]), .master_add_o(add_v[0]), .master_wen_o(wen_v[0]),
    .master_be_o(be_v[0]), .master_wdata_o(wdata_v[0]),
    .master_gnt_i(gnt), .master_r_valid_i(r_valid), .master_r_opc_i(r_opc),
    .master_r_rdata_i(r_rdata)
  );

  dift_tag_init_engine #(.TAG_BITS_NUM(4), .RMW(0)) u_wo (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_v[1]), .abort_i(abort_i),
    .addr_start_i(addr_start), .addr_end_i(addr_end), .tag_val_i(tag_val),
    .busy_o(busy_v[1]), .done_o(done_v[1]), .err_o(err_v[1]),
    .master_req_o(req_v[1]), .master_add_o(add_v[1]), .master_wen_o(wen_v[1]),
    .master_be_o(be_v[1]), .master_wdata_o(wdata_v[1]),
    .master_gnt_i(gnt), .master_r_valid_i(r_valid), .master_r_opc_i(r_opc),
    .master_r_rdata_i(r_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [35:0] wdata;
  } txn_t;

  txn_t        exp_q [$];
  logic [35:0] mem [logic [31:0]];
  int  checks = 0, errors = 0;
  int  stall_max = 0, lat_min = 0, lat_max = 0, err_read = -1;
  bit  hold_gnt = 0, exp_done_now = 0;
  int  rd_cnt = 0, wr_cnt = 0, done_cnt = 0, last_done_cyc = 0, start_c = 0;

  function automatic logic [35:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {4'h0, a ^ 32'h5A5A5A5A};
  endfunction

  task automatic check(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    check(act === exp, name, act, exp);
  endtask

  // Bus responder and per-cycle protocol checker; runs on the falling edge.
  initial begin : monitor
    int          rsp_wait;
    int          stall;
    bit          in_req, prev_done, rsp_err;
    logic [72:0] snap;
    logic [35:0] rsp_data;
    txn_t        e;
    rsp_wait = -1; stall = 0; in_req = 0; prev_done = 0; rsp_err = 0;
    snap = '0; rsp_data = '0;
    gnt = 0; r_valid = 0; r_opc = 0; r_rdata = '0;
    forever begin
      @(negedge clk);
      gnt = 0; r_valid = 0; r_opc = 0;
      if (!rst_ni) begin
        rsp_wait = -1; in_req = 0; prev_done = 0;
        continue;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        check_eq("done_allowed", exp_done_now, 1);
        check_eq("done_one_cycle", prev_done, 0);
      end
      prev_done = done;
      if (rsp_wait >= 0) begin
        check_eq("req_while_outstanding", req, 0);
        if (rsp_wait == 0) begin
          r_valid = 1; r_opc = rsp_err; r_rdata = rsp_data; rsp_wait = -1;
        end else begin
          rsp_wait--;
        end
      end else if (req) begin
        if (in_req) begin
          check_eq("req_fields_stable", {add, wen, be, wdata}, snap);
        end else begin
          in_req = 1;
          snap   = {add, wen, be, wdata};
          stall  = $urandom_range(stall_max, 0);
        end
        if (!hold_gnt && stall == 0) begin
          gnt    = 1;
          in_req = 0;
          check(exp_q.size() != 0, "txn_expected", {add, wen}, 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("txn_addr_wen_be", {add, wen, be}, {e.addr, e.wen, 4'hF});
            if (!e.wen) check_eq("txn_wdata", wdata, e.wdata);
          end
          if (wen) begin
            rsp_data = mem_rd(add);
            rsp_err  = (rd_cnt == err_read);
            rd_cnt++;
          end else begin
            mem[add] = wdata;
            rsp_data = '0;
            rsp_err  = 0;
            wr_cnt++;
          end
          rsp_wait = $urandom_range(lat_max, lat_min);
        end else if (stall > 0) begin
          stall--;
        end
      end else begin
        in_req = 0;
      end
    end
  end

  task automatic pulse_start(input logic s);
    @(negedge clk);
    start_v[s] = 1'b1;
    start_c    = cyc;
    @(negedge clk);
    start_v[s] = 1'b0;
    addr_start = $urandom;
    addr_end   = $urandom;
    tag_val    = 4'($urandom);
  endtask

  // Model: the aligned range [s,e) in 4-byte steps, each word read (RMW) then written.
  task automatic run_sweep(input logic s, input logic [31:0] a_s, input logic [31:0] a_e,
                           input logic [3:0] tg, input int err_idx);
    logic [31:0] sa, ea;
    int          n, n_wr, t;
    bit          err_hit;
    logic [31:0] wa [$];
    logic [35:0] ew [$];
    sa = a_s & ~32'h3;
    ea = a_e & ~32'h3;
    n  = (sa < ea) ? int'((ea - sa) >> 2) : 0;
    n_wr = n;
    err_hit = (s == 1'b0) && (err_idx >= 0) && (err_idx < n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      logic [35:0] w;
      a = sa + 32'(i * 4);
      w = mem_rd(a);
      w = {tg, (s == 1'b0) ? w[31:0] : 32'h0};
      if (s == 1'b0) begin
        exp_q.push_back('{addr: a, wen: 1'b1, wdata: 36'h0});
        if (i == err_idx) begin
          n_wr = i;
          break;
        end
      end
      exp_q.push_back('{addr: a, wen: 1'b0, wdata: w});
      wa.push_back(a);
      ew.push_back(w);
    end
    exp_done_now = !err_hit;
    err_read = (s == 1'b0) ? err_idx : -1;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    sel = s; addr_start = a_s; addr_end = a_e; tag_val = tg;
    pulse_start(s);
    for (t = 0; t < 3000 && busy; t++) begin
      start_v[s] = (t == 2);
      @(negedge clk);
      start_v[s] = 1'b0;
    end
    check(t < 3000, "sweep_timeout", t, 3000);
    check_eq("txn_remaining", exp_q.size(), 0);
    check_eq("done_count", done_cnt, exp_done_now ? 1 : 0);
    check_eq("err_flag", err, err_hit);
    check_eq("write_count", wr_cnt, n_wr);
    for (int i = 0; i < wa.size(); i++) check_eq("mem_word", mem_rd(wa[i]), ew[i]);
  endtask

  initial begin : stim
    int t;
    rst_ni = 1'b1;
    start_v[0] = 0; start_v[1] = 0; abort_i = 0; sel = 0;
    addr_start = '0; addr_end = '0; tag_val = '0;
    #1 rst_ni = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      check_eq("reset_state", {req_v[i], busy_v[i], done_v[i], err_v[i], wen_v[i], add_v[i], be_v[i], wdata_v[i]},
               {4'b0000, 1'b1, 32'h0, 4'h0, 36'h0});
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // Four-word read-modify-write, no stalls
    run_sweep(1'b0, 32'h1C00_0000, 32'h1C00_0010, 4'hF, -1);
    check_eq("pin_read_count", rd_cnt, 4);
    check_eq("pin_mem_1C000008", mem_rd(32'h1C00_0008), 36'hF_465A_5A52);
    check_eq("pin_busy_after", busy, 0);

    // Empty range
    run_sweep(1'b1, 32'h100, 32'h100, 4'h5, -1);
    check_eq("pin_done_latency", last_done_cyc - start_c, 1);
    check_eq("pin_no_traffic", rd_cnt + wr_cnt, 0);

    // Error response on the second read, then recovery
    run_sweep(1'b0, 32'h3000_0000, 32'h3000_0010, 4'hA, 1);
    check_eq("pin_err_writes", wr_cnt, 1);
    check_eq("pin_err_sticky", err, 1);
    run_sweep(1'b0, 32'h3000_0100, 32'h3000_0108, 4'h2, -1);

    // Top of address space
    run_sweep(1'b1, 32'hFFFF_FFF8, 32'h0, 4'h3, -1);
    check_eq("pin_wrap_no_traffic", rd_cnt + wr_cnt, 0);
    run_sweep(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 4'h3, -1);
    check_eq("pin_wrap_one_write", wr_cnt, 1);
    check_eq("pin_mem_FFFFFFF8", mem_rd(32'hFFFF_FFF8), 36'h3_0000_0000);
    run_sweep(1'b0, 32'hFFFF_FFF5, 32'hFFFF_FFFF, 4'h9, -1);

    // Randomised ranges with grant stalls and response latency
    stall_max = 5; lat_max = 2;
    for (int r = 0; r < 24; r++) begin
      logic        s;
      logic [31:0] base, a_s, a_e;
      int          n, e;
      s    = 1'($urandom);
      n    = $urandom_range(8, 0);
      base = 32'h2000_0000 + 32'($urandom_range(255, 0)) * 32'd4;
      a_s  = base | 32'($urandom_range(3, 0));
      a_e  = base + 32'(n * 4) + 32'($urandom_range(3, 0));
      if ($urandom_range(4, 0) == 0) a_e = base - 32'($urandom_range(16, 0));
      e    = ($urandom_range(3, 0) == 0) ? int'($urandom_range(8, 0)) : -1;
      run_sweep(s, a_s, a_e, 4'($urandom), e);
    end
    stall_max = 0; lat_max = 0;

    // Abort while the request is waiting for a grant
    exp_q.delete(); exp_done_now = 0; hold_gnt = 1; err_read = -1;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; sel = 0;
    addr_start = 32'h5000_0000; addr_end = 32'h5000_0010; tag_val = 4'h7;
    pulse_start(1'b0);
    check_eq("abort_req_pending", req, 1);
    repeat (2) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check_eq("abort_req_dropped", {req, busy}, 2'b00);
    @(negedge clk);
    hold_gnt = 0;
    check_eq("abort_quiet", {req, busy, done_cnt[0], rd_cnt[0], wr_cnt[0]}, 5'b0);

    // Abort in the same cycle as the grant: the response is still drained
    lat_min = 3; lat_max = 3; sel = 1; rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    exp_q.delete();
    exp_q.push_back('{addr: 32'h6000_0000, wen: 1'b0, wdata: 36'h4_0000_0000});
    addr_start = 32'h6000_0000; addr_end = 32'h6000_0010; tag_val = 4'h4;
    pulse_start(1'b1);
    #1;
    check_eq("abort_gnt_seen", gnt, 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check_eq("abort_waits_rsp", busy, 1);
    for (t = 0; t < 100 && busy; t++) @(negedge clk);
    check(t < 100, "abort_timeout", t, 100);
    check_eq("abort_gnt_result", {wr_cnt[3:0], done_cnt[3:0], err, 6'(exp_q.size())}, {4'd1, 4'd0, 1'b0, 6'd0});

    // Reset while a write response is outstanding
    lat_min = 4; lat_max = 4; wr_cnt = 0;
    exp_q.delete();
    exp_q.push_back('{addr: 32'h7000_0000, wen: 1'b0, wdata: 36'h8_0000_0000});
    addr_start = 32'h7000_0000; addr_end = 32'h7000_0010; tag_val = 4'h8;
    pulse_start(1'b1);
    #1;
    check_eq("rst_gnt_seen", gnt, 1);
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("rst_mid_outputs", {req, busy, done, err, wen, add, be, wdata},
             {4'b0000, 1'b1, 32'h0, 4'h0, 36'h0});
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_ni = 1'b1;
    exp_q.delete(); lat_min = 0; lat_max = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("rst_after_idle", {req, busy, done}, 3'b000);
    end
    check_eq("rst_no_more_writes", wr_cnt, 1);

    // Engine is usable again after reset
    run_sweep(1'b1, 32'h0000_0040, 32'h0000_0048, 4'hC, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/dift_tag_init_engine.md
DIFT_TAG_INIT_ENGINE -- requirements
Module: dift_tag_init_engine

Interface
REQ-001 Parameter TAG_BITS_NUM, default 4: number of tag bits per word, carried in bus bits [35:32]; only 4 is supported.
REQ-002 Parameter RMW, default 1: 1 = read-modify-write, preserving data; 0 = write-only, zero-filling data.
REQ-003 clk_i  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1: reset, asynchronous and active-low.
REQ-005 start_i  input  1: start pulse; sampled only in IDLE.
REQ-006 abort_i  input  1: stop request; sampled in every non-IDLE state.
REQ-007 addr_start_i  input  32: first word address; bits [1:0] are ignored and treated as 0.
REQ-008 addr_end_i  input  32: end address, exclusive; bits [1:0] are ignored.
REQ-009 tag_val_i  input  4: tag value written to every word.
REQ-010 busy_o  output  1: high while a sweep is in progress.
REQ-011 done_o  output  1: one-cycle pulse on normal completion.
REQ-012 err_o  output  1: sticky error flag; cleared on the next accepted start.
REQ-013 master  XBAR_TCDM_BUS_36.Master: TCDM master port (req, add, wen, be, wdata[35:0] out; gnt, r_valid, r_opc, r_rdata[35:0] in); feeds the tag-override/interconnect path.

Function
REQ-014 States: IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP, FIN.
REQ-015 IDLE + start_i: latch start, end and tag; clear err_o; cur_addr <= start.
- If start >= end: go to FIN with no bus traffic.
- Otherwise: go to RD_REQ when RMW=1, WR_REQ when RMW=0.
REQ-016 RD_REQ: req=1, wen=1, add=cur_addr, be=4'hF. Hold req and all fields stable until gnt; on gnt go to RD_RSP.
REQ-017 RD_RSP: wait for r_valid. On r_valid, capture r_rdata[31:0] into a data register and go to WR_REQ; req=0 in this state.
REQ-018 WR_REQ: req=1, wen=0, add=cur_addr, be=4'hF.
- wdata[31:0] = captured data (RMW=1) or 0 (RMW=0).
- wdata[35:32] = latched tag.
- Hold until gnt; then go to WR_RSP.
REQ-019 WR_RSP: wait for r_valid, then cur_addr <= cur_addr+4.
- If the new address >= end, or the +4 wrapped past 2^32: go to FIN.
- Otherwise: go to RD_REQ or WR_REQ per RMW.
REQ-020 FIN: done_o=1 for exactly one cycle, then IDLE.
REQ-021 At most one transaction is outstanding; req is never asserted in RD_RSP, WR_RSP, FIN or IDLE.
REQ-022 An r_valid with r_opc=1 in RD_RSP or WR_RSP sets err_o and goes to IDLE without a done pulse. In RD_RSP the write for that word is not issued.
REQ-023 Abort handling:
- abort_i in RD_REQ or WR_REQ before gnt: drop req next cycle, go to IDLE, no done pulse.
- abort_i while a grant or response is pending: complete the current handshake, then go to IDLE.
REQ-024 An abort arriving in the same cycle as gnt counts as granted; the response is awaited before going to IDLE.
REQ-025 busy_o is high in every state except IDLE. busy_o falls in the cycle after FIN or the error/abort exit.
REQ-026 start_i while busy is ignored. Input changes during a sweep have no effect, since the values are latched.
REQ-027 Responses may arrive one or more cycles after gnt, and r_valid may never coincide with gnt of the same request.
REQ-028 Throughput: RMW=1 needs 4 cycles minimum per word; RMW=0 needs 2 cycles minimum per word.

Reset
REQ-029 When rst_ni is low, regardless of clock:
- state=IDLE; req, busy_o, done_o, err_o all 0.
- add, wdata, be, wen driven 0/1'b1 (wen=1).
- Internal registers set to 0.
REQ-030 Reset mid-transaction abandons the transaction; after release the block is in IDLE and issues no request.

Verification
REQ-031 RMW=1, start=0x1C000000, end=0x1C000010, tag=4'hF, gnt immediate, r_valid +1 cycle, memory pre-filled with tags 0 -> exactly 4 reads and 4 writes at +0, +4, +8, +C; data unchanged, tags=F; single done pulse; busy_o low after.
REQ-032 RMW=0, start=end=0x100 -> no req asserted; done pulse 1 cycle after start; err_o=0.
REQ-033 Random gnt stalls of 0-5 cycles -> req, add, wen, wdata and be stay stable until gnt each time; write count equals (end-start)/4.
REQ-034 r_opc=1 on the second read -> err_o=1, no second write, no done pulse, IDLE; next start clears err_o.
REQ-035 start=0xFFFFFFF8, end=0x0 with RMW=0 -> start >= end, so no traffic and done only. Separately, start=0xFFFFFFF8, end=0xFFFFFFFC -> one write; termination at wrap.
REQ-036 abort_i asserted while req is waiting for gnt -> req drops next cycle, IDLE, no done. Also: rst_ni pulsed low during WR_RSP -> all outputs 0 immediately; no activity after release.
